fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 Parameter STOP_BITS, default 1, meaning number of stop bits per frame; legal values 1 or 2.
REQ-003 Port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port data_in, input, 8, byte offered by the upstream rv_fifo data_out.
REQ-006 Port valid_in, input, 1, upstream byte valid (rv_fifo valid_out).
REQ-007 Port ready_in, output, 1, block accepts a byte this cycle (drives rv_fifo ready_out).
REQ-008 Port uart_tx, output, 1, serial line; idle high.
REQ-009 Port busy, output, 1, high while a frame is in progress.
REQ-010 Port tx_done, output, 1, single-cycle pulse at the end of each frame.

Function
REQ-011 The block SHALL transfer a byte only on a cycle where valid_in and ready_in are both high; data_in is latched on that edge.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, (PARITY), STOP; accepting a byte moves IDLE->START.
REQ-013 uart_tx SHALL be registered, and the start bit (0) SHALL appear on the cycle after the accept edge.
REQ-014 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at every bit boundary.
REQ-015 Data bits SHALL be sent LSB first, with a 3-bit index; the DATA->next-state transition occurs after bit 7 completes.
REQ-016 The STOP state SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-017 ready_in SHALL be high in IDLE and on the final cycle of STOP, and low otherwise.
REQ-018 If valid_in is high on the final STOP cycle, the next start bit SHALL follow with zero idle gap (back-to-back frames).
REQ-019 tx_done SHALL pulse high on the final cycle of STOP, coincident with the REQ-017 ready_in.
REQ-020 busy SHALL be low only in IDLE.
REQ-021 Changes on data_in or valid_in mid-frame SHALL have no effect on the frame in progress.
REQ-022 valid_in is low (upstream FIFO empty): the block SHALL stay in IDLE with uart_tx=1 indefinitely.

Reset
REQ-023 While rst is high, the outputs SHALL take these values on the next edge: uart_tx=1, ready_in=0, busy=0, tx_done=0; the state SHALL be IDLE, and all counters and the shift register SHALL clear.
REQ-024 On the first cycle after rst deasserts, ready_in SHALL be 1.
REQ-025 A reset mid-frame SHALL abort the frame: uart_tx=1 on the next cycle, and the partial byte is discarded rather than re-sent.

Configuration
REQ-026 Macro FIFO_UART_TX_PARITY_EN, when defined, SHALL insert a PARITY state between DATA and STOP that sends one even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 11-bit frame when STOP_BITS=1.
REQ-027 Without FIFO_UART_TX_PARITY_EN, there SHALL be no PARITY state or parity logic, and the frame is 8N1, 10 bits.

Structure
REQ-028 A shared package uart_pkg SHALL hold the FSM state encoding, UART_DATA_BITS=8, and the default CLKS_PER_BIT constant.
REQ-029 One sub-module, baud_tick_gen, SHALL provide the bit-period counter with a reload input and a one-cycle tick output at terminal count; the shifter and FSM stay in fifo_uart_tx.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-030 Reset, then data_in=8'hA5 with valid_in=1 for one cycle; uart_tx SHALL read 0,1,0,1,0,0,1,0,1,1, each level held for 4 cycles, with tx_done on cycle 40 after the accept.
REQ-031 Keep valid_in high across 3 bytes 8'h00, 8'hFF, 8'h55; the frames SHALL be contiguous with zero idle cycles, and ready_in high exactly 3 times, once on each frame's final cycle.
REQ-032 Assert rst during bit 4 of 8'h3C; uart_tx SHALL be 1 on the next cycle, busy=0, and ready_in=1 on the first cycle after rst falls; no residual bits are sent.
REQ-033 Toggle data_in randomly and pulse valid_in mid-frame; the transmitted frame SHALL equal the originally accepted byte, with no extra accepts.
REQ-034 With FIFO_UART_TX_PARITY_EN defined, send 8'h07; the parity bit SHALL be 1 and the frame 11 bits (44 cycles); send 8'h03 and the parity bit SHALL be 0.
REQ-035 With STOP_BITS=2, send 8'h81; the stop level SHALL last 8 cycles and tx_done SHALL occur on cycle 44.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit period.
// The PARITY state exists only when FIFO_UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;
`endif

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period down-counter: reload restarts a full bit, tick marks the last cycle of a bit.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q - 16'd1;
    if (reload || cnt_q == 16'd0) begin
      cnt_d = TERM;
    end
    tick = (cnt_q == 16'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a ready/valid FIFO; 8N1 frames, or 8E1 when
// FIFO_UART_TX_PARITY_EN is defined. Back-to-back frames have no idle gap.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_in,
  output logic       uart_tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       tx_q, tx_d;
  logic       rst_hold_q;
  logic       reload;
  logic       tick;
  logic       accept;
`ifdef FIFO_UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .reload(reload),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    reload     = 1'b0;
    tx_done    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      ST_IDLE: tx_d = 1'b1;
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'd0;
          reload    = 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          reload = 1'b1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d    = ST_STOP;
            tx_d       = 1'b1;
            stop_idx_d = 1'b0;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
          reload     = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          reload = 1'b1;
          if (stop_idx_q == STOP_LAST) begin
            tx_done = 1'b1;
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // The final stop cycle accepts too, so a waiting byte starts with no gap.
    ready_in = !rst_hold_q && (state_q == ST_IDLE || tx_done);
    accept   = valid_in && ready_in;
    if (accept) begin
      state_d = ST_START;
      shift_d = data_in;
      tx_d    = 1'b0;
      reload  = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d = ^data_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      rst_hold_q <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      rst_hold_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign uart_tx = tx_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4; a second instance covers STOP_BITS=2.
// Honours FIFO_UART_TX_PARITY_EN when defined for the build.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in, data2;
  logic       valid_in, valid2;
  logic       ready_in, uart_tx, busy, tx_done;
  logic       ready2, tx2, busy2, done2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .uart_tx(uart_tx), .busy(busy), .tx_done(tx_done)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(data2), .valid_in(valid2),
    .ready_in(ready2), .uart_tx(tx2), .busy(busy2), .tx_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [11:0] frame_of(input logic [7:0] b);
    logic [11:0] p;
    p      = 12'hFFF;
    p[0]   = 1'b0;
    p[8:1] = b;
`ifdef FIFO_UART_TX_PARITY_EN
    p[9]   = ^b;
`endif
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called on cycle 1 after an accept; returns on the cycle after the frame's last cycle.
  task automatic run_frame(input string name, input logic [11:0] pat, input bit noise,
                           output logic [11:0] obs);
    int last;
    last = NB * CPB;
    obs  = 12'hFFF;
    for (int c = 1; c <= last; c++) begin
      if (noise) begin
        if (c < last) begin
          data_in  = 8'($urandom);
          valid_in = (c % 3 == 0);
        end else begin
          valid_in = 1'b0;
        end
      end
      if ((c - 1) % CPB == 2) obs[(c - 1) / CPB] = uart_tx;
      chk($sformatf("%s tx c%0d", name, c), uart_tx, pat[(c - 1) / CPB]);
      chk($sformatf("%s done c%0d", name, c), tx_done, (c == last));
      chk($sformatf("%s ready c%0d", name, c), ready_in, (c == last));
      chk($sformatf("%s busy c%0d", name, c), busy, 1);
      step();
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk($sformatf("%s idle tx", name), uart_tx, 1);
      chk($sformatf("%s idle busy", name), busy, 0);
      chk($sformatf("%s idle ready", name), ready_in, 1);
      step();
    end
  endtask

  task automatic accept(input logic [7:0] b);
    data_in  = b;
    valid_in = 1'b1;
    chk("ready before accept", ready_in, 1);
    step();
  endtask

  initial begin
    logic [11:0] obs;
    logic [11:0] p;
    int stop_len;

    rst = 1'b1; valid_in = 1'b0; data_in = 8'h00; valid2 = 1'b0; data2 = 8'h00;
    step();
    step();
    chk("rst tx", uart_tx, 1);
    chk("rst ready", ready_in, 0);
    chk("rst busy", busy, 0);
    chk("rst done", tx_done, 0);
    chk("rst tx2", tx2, 1);
    chk("rst ready2", ready2, 0);
    rst = 1'b0;
    step();
    chk("ready after rst", ready_in, 1);
    chk("ready2 after rst", ready2, 1);
    check_idle("empty", 6);

    // Single A5 frame: start + data bits 1,0,1,0,0,1,0,1 (LSB first)
    accept(8'hA5);
    valid_in = 1'b0;
    run_frame("a5", frame_of(8'hA5), 1'b0, obs);
    chk("a5 start+data", obs[8:0], 9'b101001010);
    chk("a5 stop", obs[NB-1], 1);
    check_idle("after a5", 3);

    // Back-to-back 00, FF, 55 with valid held high
    accept(8'h00);
    data_in = 8'hFF;
    run_frame("b00", frame_of(8'h00), 1'b0, obs);
    data_in = 8'h55;
    run_frame("bff", frame_of(8'hFF), 1'b0, obs);
    valid_in = 1'b0;
    run_frame("b55", frame_of(8'h55), 1'b0, obs);
    chk("b55 data", obs[8:1], 8'h55);
    check_idle("after b2b", 3);

    // Reset during data bit 4 of 3C (frame cycles 21..24)
    accept(8'h3C);
    valid_in = 1'b0;
    p = frame_of(8'h3C);
    for (int c = 1; c < 22; c++) begin
      chk($sformatf("3c tx c%0d", c), uart_tx, p[(c - 1) / CPB]);
      step();
    end
    rst = 1'b1;
    step();
    chk("midrst tx", uart_tx, 1);
    chk("midrst busy", busy, 0);
    chk("midrst ready", ready_in, 0);
    chk("midrst done", tx_done, 0);
    rst = 1'b0;
    step();
    chk("midrst ready after", ready_in, 1);
    check_idle("after midrst", 50);

    // Noisy inputs mid-frame must not disturb C3 nor trigger extra accepts
    accept(8'hC3);
    run_frame("noise", frame_of(8'hC3), 1'b1, obs);
    chk("noise data", obs[8:1], 8'hC3);
    check_idle("after noise", 8);

`ifdef FIFO_UART_TX_PARITY_EN
    accept(8'h07);
    valid_in = 1'b0;
    run_frame("p07", frame_of(8'h07), 1'b0, obs);
    chk("p07 parity", obs[9], 1);
    accept(8'h03);
    valid_in = 1'b0;
    run_frame("p03", frame_of(8'h03), 1'b0, obs);
    chk("p03 parity", obs[9], 0);
    check_idle("after parity", 3);
`endif

    // Two stop bits: 8 stop cycles, tx_done on the final one
    data2 = 8'h81;
    valid2 = 1'b1;
    chk("ready2 before accept", ready2, 1);
    step();
    valid2 = 1'b0;
    p = frame_of(8'h81);
    stop_len = 0;
    for (int c = 1; c <= (NB + 1) * CPB; c++) begin
      chk($sformatf("s2 tx c%0d", c), tx2, (c > (NB - 1) * CPB) ? 1'b1 : p[(c - 1) / CPB]);
      chk($sformatf("s2 done c%0d", c), done2, (c == (NB + 1) * CPB));
      if (c > (NB - 1) * CPB && tx2 === 1'b1) stop_len++;
      step();
    end
    chk("s2 stop length", stop_len, 2 * CPB);
    chk("s2 idle busy", busy2, 0);
    chk("s2 idle tx", tx2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
